// File: rtl/lif_decoder_pkg.sv
// Shared types, constants and helpers for the LIF spike decoder.
package lif_decoder_pkg;

   // Decoder operating state
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRate = 2'd1,
      StIsi  = 2'd2
   } state_e;

   // Base rate-window length; the window is WIN_BASE << S cycles
   localparam int unsigned WIN_BASE = 16;
   // Saturation ceiling for the 8-bit counters and results
   localparam int unsigned SAT_MAX  = 255;

   // ui_in field positions
   localparam int unsigned UI_SPIKE_BIT = 0;
   localparam int unsigned UI_SEL_LSB   = 1;
   localparam int unsigned UI_MODE_BIT  = 4;
   localparam int unsigned UI_RUN_BIT   = 5;

   // uio field positions
   localparam int unsigned UIO_ACK_BIT   = 0;
   localparam int unsigned UIO_VALID_BIT = 1;
   localparam int unsigned UIO_OVR_BIT   = 2;

   // Only valid and overrun are driven out on the bidirectional pins
   localparam logic [7:0] UIO_OE_VAL = 8'b0000_0110;

   // 8-bit add of a single bit, clamped at SAT_MAX
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic b);
      logic [8:0] w_sum;
      w_sum = {1'b0, a} + {8'd0, b};
      return w_sum[8] ? 8'(SAT_MAX) : w_sum[7:0];
   endfunction

   // Reload value of the 11-bit window down-counter: (WIN_BASE << sel) - 1
   function automatic logic [10:0] win_load(input logic [2:0] sel);
      logic [11:0] w_len;
      w_len = 12'(WIN_BASE) << sel;
      return 11'(w_len - 12'd1);
   endfunction

endpackage

// File: rtl/spike_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A 0->1 input first sampled at edge k yields a one-cycle pulse after edge k+2.
// With i_en low every flop holds, so no edge can be detected.
module spike_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_async,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_pulse;

   // Synchronizer chain, edge history and registered pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else if (i_en) begin
         r_meta  <= i_async;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_pulse <= r_sync & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/tt_um_lif_spike_decoder.sv
// LIF spike decoder: measures spike rate over a programmable window or the
// interval between consecutive spikes, and hands results to a reader through
// a valid/ack handshake with a sticky overrun flag.
module tt_um_lif_spike_decoder
   import lif_decoder_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Control fields
   logic       w_run;
   logic       w_mode;
   logic [2:0] w_sel;

   assign w_run  = ui_in[UI_RUN_BIT];
   assign w_mode = ui_in[UI_MODE_BIT];
   assign w_sel  = ui_in[UI_SEL_LSB +: 3];

   // Reserved input bits are deliberately ignored
   logic w_unused;
   assign w_unused = ^{ui_in[7:6], uio_in[7:1]};

   // Synchronized edge pulses
   logic w_spike_pulse;
   logic w_ack_pulse;

   spike_sync u_spike_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (ena),
      .i_async (ui_in[UI_SPIKE_BIT]),
      .o_pulse (w_spike_pulse)
   );

   spike_sync u_ack_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (ena),
      .i_async (uio_in[UIO_ACK_BIT]),
      .o_pulse (w_ack_pulse)
   );

   // State and datapath registers
   state_e      r_state;
   state_e      w_state_next;
   logic [2:0]  r_sel;
   logic [10:0] r_win;
   logic [7:0]  r_spk_cnt;
   logic [7:0]  r_isi_cnt;
   logic        r_seen;

   // Result handshake registers
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_ovr;

   // Decoded strobes
   logic        w_start;
   logic        w_res_vld;
   logic [7:0]  w_res;

   // Next-state decode and result generation
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_res_vld    = 1'b0;
      w_res        = '0;
      unique case (r_state)
         StIdle: begin
            if (w_run) begin
               w_start      = 1'b1;
               w_state_next = w_mode ? StIsi : StRate;
            end
         end
         StRate: begin
            if (!w_run) begin
               w_state_next = StIdle;
            end else if (r_win == '0) begin
               // A spike landing on the last window cycle still belongs to it
               w_res_vld = 1'b1;
               w_res     = sat_add(r_spk_cnt, w_spike_pulse);
            end
         end
         StIsi: begin
            if (!w_run) begin
               w_state_next = StIdle;
            end else if (w_spike_pulse && r_seen) begin
               w_res_vld = 1'b1;
               w_res     = r_isi_cnt;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else if (ena) begin
         r_state <= w_state_next;
      end
   end

   // Window, spike and interval counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel     <= '0;
         r_win     <= '0;
         r_spk_cnt <= '0;
         r_isi_cnt <= '0;
         r_seen    <= 1'b0;
      end else if (ena) begin
         if (w_start) begin
            // Window select is frozen for the whole run
            r_sel     <= w_sel;
            r_win     <= win_load(w_sel);
            r_spk_cnt <= '0;
            r_isi_cnt <= '0;
            r_seen    <= 1'b0;
         end else if (w_state_next == StIdle) begin
            // Partial measurements are discarded when run drops
            r_win     <= '0;
            r_spk_cnt <= '0;
            r_isi_cnt <= '0;
            r_seen    <= 1'b0;
         end else if (r_state == StRate) begin
            if (r_win == '0) begin
               // Back-to-back windows: reload without a dead cycle
               r_win     <= win_load(r_sel);
               r_spk_cnt <= '0;
            end else begin
               r_win     <= r_win - 11'd1;
               r_spk_cnt <= sat_add(r_spk_cnt, w_spike_pulse);
            end
         end else begin
            if (w_spike_pulse) begin
               r_isi_cnt <= 8'd1;
               r_seen    <= 1'b1;
            end else begin
               r_isi_cnt <= sat_add(r_isi_cnt, 1'b1);
            end
         end
      end
   end

   // Result register with valid/ack handshake and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (ena) begin
         if (w_res_vld) begin
            r_data  <= w_res;
            r_valid <= 1'b1;
            // Only an unread result that is not being acked right now is lost
            if (r_valid && !w_ack_pulse) begin
               r_ovr <= 1'b1;
            end
         end else if (w_ack_pulse && r_valid) begin
            r_valid <= 1'b0;
         end
         if (w_start) begin
            r_ovr <= 1'b0;
         end
      end
   end

   // Output pin mapping
   always_comb begin
      uio_out                = '0;
      uio_out[UIO_VALID_BIT] = r_valid;
      uio_out[UIO_OVR_BIT]   = r_ovr;
   end

   assign uo_out = r_data;
   assign uio_oe = UIO_OE_VAL;

endmodule
